// File: rtl/hex_display_driver.sv
// ---------------------------------------------------------------------------
// hex_display_driver
//
// Multi-digit hexadecimal driver for active-low seven-segment displays.
// Holds a DIGITS-nibble value register that can be cleared, loaded in
// parallel, or filled calculator-style by shifting nibbles in at digit 0.
// Every digit gets a registered seven-segment pattern, with optional
// leading-zero blanking and per-digit blinking from an internal divider.
//
// Parameters:
//   DIGITS     number of displayed digits (1..8)
//   BLINK_DIV  clock cycles per blink half-period (>=2)
//
// Ports:
//   Clock       in   system clock, rising edge
//   Reset       in   asynchronous active-high reset, clears all state
//   Clear       in   synchronous clear of the value register (highest priority)
//   Load        in   parallel load of Data (beats Shift)
//   Data        in   parallel value, digit i = Data[4i+3:4i]
//   Shift       in   shift value left one nibble, Nibble enters digit 0
//   Nibble      in   digit entered by Shift
//   BlankZeros  in   enable leading-zero blanking
//   BlinkEn     in   per-digit blink mask
//   Value       out  current value register
//   HEX         out  active-low segments, digit i = HEX[7i+6:7i], bit 6 = a
// ---------------------------------------------------------------------------
module hex_display_driver #(
    parameter int DIGITS    = 4,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Clear,
    input  logic                  Load,
    input  logic [4*DIGITS-1:0]   Data,
    input  logic                  Shift,
    input  logic [3:0]            Nibble,
    input  logic                  BlankZeros,
    input  logic [DIGITS-1:0]     BlinkEn,
    output logic [4*DIGITS-1:0]   Value,
    output logic [7*DIGITS-1:0]   HEX
);

    localparam int              CNT_W   = $clog2(BLINK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

    logic [4*DIGITS-1:0] value_reg;
    logic [4*DIGITS-1:0] value_next;
    logic [4*DIGITS-1:0] value_shifted;
    logic [CNT_W-1:0]    cnt_reg;
    logic                phase_reg;
    logic [7*DIGITS-1:0] hex_reg;
    logic [7*DIGITS-1:0] hex_next;
    logic [DIGITS-1:0]   digit_zero;
    logic [DIGITS-1:0]   zero_from_top;  // digit i and every digit above it are 0
    logic [DIGITS-1:0]   blank;

    // Active-low segment pattern, bit 6 = a ... bit 0 = g.
    function automatic logic [6:0] encode(input logic [3:0] d);
        logic [6:0] seg;
        case (d)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

    // A single-digit display has nothing to shift up; Nibble simply replaces it.
    generate
        if (DIGITS == 1) begin : g_shift_one
            assign value_shifted = Nibble;
        end else begin : g_shift_many
            assign value_shifted = {value_reg[4*DIGITS-5:0], Nibble};
        end
    endgenerate

    always_comb begin
        value_next = value_reg;
        if (Clear) begin
            value_next = '0;
        end else if (Load) begin
            value_next = Data;
        end else if (Shift) begin
            value_next = value_shifted;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign digit_zero[gi] = (value_reg[4*gi +: 4] == 4'h0);

            if (gi == DIGITS - 1) begin : g_top
                assign zero_from_top[gi] = digit_zero[gi];
            end else begin : g_below
                assign zero_from_top[gi] = digit_zero[gi] & zero_from_top[gi+1];
            end

            // Digit 0 always shows something, even when the whole value is 0.
            if (gi == 0) begin : g_units
                assign blank[gi] = phase_reg & BlinkEn[gi];
            end else begin : g_upper
                assign blank[gi] = (BlankZeros & zero_from_top[gi]) |
                                   (phase_reg & BlinkEn[gi]);
            end

            assign hex_next[7*gi +: 7] = blank[gi] ? 7'b1111111
                                                   : encode(value_reg[4*gi +: 4]);
        end
    endgenerate

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            value_reg <= '0;
            cnt_reg   <= '0;
            phase_reg <= 1'b0;
            hex_reg   <= '1;
        end else begin
            value_reg <= value_next;
            hex_reg   <= hex_next;
            if (cnt_reg == CNT_MAX) begin
                cnt_reg   <= '0;
                phase_reg <= ~phase_reg;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign Value = value_reg;
    assign HEX   = hex_reg;

endmodule

// File: tb/tb_hex_display_driver.sv
// ---------------------------------------------------------------------------
// tb_hex_display_driver
//
// Directed self-checking bench for hex_display_driver with DIGITS=4 and
// BLINK_DIV=4. Each task drives one scenario and checks Value/HEX against
// hand-computed patterns one time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_hex_display_driver;

    localparam logic [6:0] S0 = 7'b0000001;
    localparam logic [6:0] S1 = 7'b1001111;
    localparam logic [6:0] S2 = 7'b0010010;
    localparam logic [6:0] S3 = 7'b0000110;
    localparam logic [6:0] S4 = 7'b1001100;
    localparam logic [6:0] S5 = 7'b0100100;
    localparam logic [6:0] S7 = 7'b0001111;
    localparam logic [6:0] S9 = 7'b0000100;
    localparam logic [6:0] SA = 7'b0001000;
    localparam logic [6:0] SF = 7'b0111000;
    localparam logic [6:0] SB = 7'b1111111;  // blank

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Clear = 1'b0;
    logic        Load = 1'b0;
    logic [15:0] Data = 16'h0000;
    logic        Shift = 1'b0;
    logic [3:0]  Nibble = 4'h0;
    logic        BlankZeros = 1'b0;
    logic [3:0]  BlinkEn = 4'b0000;
    logic [15:0] Value;
    logic [27:0] HEX;

    int total = 0;
    int bad = 0;

    hex_display_driver #(
        .DIGITS(4),
        .BLINK_DIV(4)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .Clear(Clear),
        .Load(Load),
        .Data(Data),
        .Shift(Shift),
        .Nibble(Nibble),
        .BlankZeros(BlankZeros),
        .BlinkEn(BlinkEn),
        .Value(Value),
        .HEX(HEX)
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk_value(input string name, input logic [15:0] exp);
        total++;
        if (Value !== exp) begin
            bad++;
            $display("FAIL %s: Value=%h expected %h", name, Value, exp);
        end else begin
            $display("ok   %s: Value=%h", name, Value);
        end
    endtask

    task automatic chk_hex(input string name, input logic [27:0] exp);
        total++;
        if (HEX !== exp) begin
            bad++;
            $display("FAIL %s: HEX=%b expected %b", name, HEX, exp);
        end else begin
            $display("ok   %s: HEX=%b", name, HEX);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        tick();
        chk_hex("reset_hex_blank", {4{SB}});
        chk_value("reset_value", 16'h0000);
        Reset = 1'b0;
        tick();
        chk_hex("post_reset_zeros", {S0, S0, S0, S0});
    endtask

    task automatic test_load();
        Data = 16'h1A3F;
        Load = 1'b1;
        tick();
        Load = 1'b0;
        chk_value("load_value", 16'h1A3F);
        chk_hex("load_hex_latency", {S0, S0, S0, S0});
        tick();
        chk_hex("load_hex", {S1, SA, S3, SF});
    endtask

    task automatic test_shift_blank();
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
        chk_value("clear_value", 16'h0000);
        Shift = 1'b1;
        Nibble = 4'h7;
        tick();
        Nibble = 4'h2;
        tick();
        Nibble = 4'h9;
        tick();
        Shift = 1'b0;
        chk_value("shift_729", 16'h0729);
        BlankZeros = 1'b1;
        tick();
        chk_hex("lz_blank_729", {SB, S7, S2, S9});
        Data = 16'h0305;
        Load = 1'b1;
        tick();
        Load = 1'b0;
        tick();
        chk_hex("lz_inner_zero_kept", {SB, S3, S0, S5});
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
        tick();
        chk_hex("lz_zero_value", {SB, SB, SB, S0});
        BlankZeros = 1'b0;
        tick();
        chk_hex("lz_disabled", {S0, S0, S0, S0});
        // Five shifts into a four-digit register: top digit falls off.
        Shift = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            Nibble = 4'(n);
            tick();
        end
        Shift = 1'b0;
        chk_value("shift_overflow", 16'h2345);
    endtask

    task automatic test_priority();
        Data = 16'h00FF;
        Nibble = 4'h3;
        Load = 1'b1;
        Shift = 1'b1;
        tick();
        chk_value("load_beats_shift", 16'h00FF);
        Data = 16'hFFFF;
        Clear = 1'b1;
        tick();
        chk_value("clear_beats_load", 16'h0000);
        Load = 1'b0;
        tick();
        chk_value("clear_beats_shift", 16'h0000);
        Clear = 1'b0;
        Shift = 1'b0;
        tick();
        chk_value("hold", 16'h0000);
    endtask

    task automatic test_blink();
        logic [6:0] exp_d0;
        // Restart the divider so the blink phase is known relative to edge count.
        Reset = 1'b1;
        #2;
        Reset = 1'b0;
        BlankZeros = 1'b0;
        BlinkEn = 4'b0001;
        Data = 16'h0005;
        Load = 1'b1;
        for (int n = 1; n <= 17; n++) begin
            tick();
            Load = 1'b0;
            if (n >= 2) begin
                // Phase becomes 1 at edges 4..7, 12..15; HEX follows one edge later.
                exp_d0 = (((n - 1) / 4) % 2 == 1) ? SB : S5;
                chk_hex($sformatf("blink_edge%0d", n), {S0, S0, S0, exp_d0});
            end
        end
    endtask

    task automatic test_async_reset();
        Reset = 1'b1;
        #2;
        Reset = 1'b0;
        BlinkEn = 4'b0001;
        Data = 16'h1234;
        Load = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            tick();
            Load = 1'b0;
        end
        chk_hex("pre_reset_blank_phase", {S1, S2, S3, SB});
        #3;
        Reset = 1'b1;
        #1;
        chk_hex("async_reset_hex", {4{SB}});
        chk_value("async_reset_value", 16'h0000);
        #1;
        Reset = 1'b0;
        Load = 1'b1;
        tick();
        Load = 1'b0;
        chk_hex("restart_edge1", {S0, S0, S0, S0});
        for (int n = 2; n <= 5; n++) begin
            tick();
            chk_hex($sformatf("restart_edge%0d", n),
                    (n == 5) ? {S1, S2, S3, SB} : {S1, S2, S3, S4});
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_shift_blank();
        test_priority();
        test_blink();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, total=%0d", total);
        $fatal(1, "timeout");
    end

endmodule
